// File: rtl/lif_pkg.sv
// rtl/lif_pkg.sv - shared types and constants for the lif neuron datapath
//
// Holds the window FSM state encoding, the width and range of the unsigned
// current that feeds lif, and the default weight/accumulator widths used by
// the stages that drive it.

package lif_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCUM   = 2'd1,
    PUBLISH = 2'd2
  } state_t;

  localparam int CUR_WIDTH         = 8;
  localparam int CUR_MAX           = 255;

  localparam int DEFAULT_W_WIDTH   = 8;
  localparam int DEFAULT_ACC_WIDTH = 12;

endpackage

// File: rtl/acc_clamp.sv
// rtl/acc_clamp.sv - signed accumulator to unsigned lif current clamp
//
// Purely combinational.
//   acc     in  ACC_WIDTH  signed accumulator value
//   current out CUR_WIDTH  acc clamped to 0..CUR_MAX

module acc_clamp
  import lif_pkg::*;
#(
  parameter int ACC_WIDTH = DEFAULT_ACC_WIDTH
) (
  input  logic signed [ACC_WIDTH-1:0] acc,
  output logic        [CUR_WIDTH-1:0] current
);

  localparam logic signed [ACC_WIDTH-1:0] CUR_MAX_ACC = ACC_WIDTH'(CUR_MAX);

  always_comb begin
    current = '0;
    if (acc[ACC_WIDTH-1]) begin
      current = '0;
    end else if (acc > CUR_MAX_ACC) begin
      current = CUR_WIDTH'(CUR_MAX);
    end else begin
      current = acc[CUR_WIDTH-1:0];
    end
  end

endmodule

// File: rtl/synapse_accumulator.sv
// rtl/synapse_accumulator.sv - windowed weighted spike accumulator feeding lif
//
// Sums the programmed weight of every accepted spike event over a window of
// TICK_CYCLES clocks, then publishes the clamped sum as the lif current.
//   clk, rst_n     clock, asynchronous active-low reset
//   ev_valid/ready spike event handshake, ev_syn = synapse index
//   wr_en/addr/data weight register file write port
//   current        published current, held for a whole window
//   current_valid  one-cycle pulse when current updates
//   tick           one-cycle window boundary pulse, aligned with current_valid

module synapse_accumulator
  import lif_pkg::*;
#(
  parameter int NUM_SYN     = 8,
  parameter int W_WIDTH     = DEFAULT_W_WIDTH,
  parameter int ACC_WIDTH   = DEFAULT_ACC_WIDTH,
  parameter int TICK_CYCLES = 16,
  localparam int IDX_W      = (NUM_SYN > 1) ? $clog2(NUM_SYN) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ev_valid,
  output logic                 ev_ready,
  input  logic [IDX_W-1:0]     ev_syn,
  input  logic                 wr_en,
  input  logic [IDX_W-1:0]     wr_addr,
  input  logic [W_WIDTH-1:0]   wr_data,
  output logic [CUR_WIDTH-1:0] current,
  output logic                 current_valid,
  output logic                 tick
);

  localparam int CNT_W = (TICK_CYCLES > 2) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TICK_CYCLES - 2);
  localparam logic [IDX_W:0] NUM_SYN_EXT = (IDX_W + 1)'(NUM_SYN);

  localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  state_t                      state_q, state_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic signed [W_WIDTH-1:0]   weight [NUM_SYN];
  logic signed [ACC_WIDTH-1:0] acc;
  logic signed [ACC_WIDTH-1:0] acc_sat;
  logic signed [ACC_WIDTH:0]   sum_ext;
  logic signed [W_WIDTH-1:0]   w_sel;
  logic [CUR_WIDTH-1:0]        clamp_cur;
  logic                        ev_accept;
  logic                        ev_in_range;
  logic                        wr_in_range;

  // ---------------- window FSM ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        state_d = ACCUM;
        cnt_d   = '0;
      end
      ACCUM: begin
        if (cnt_q == LAST_CNT) begin
          state_d = PUBLISH;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      PUBLISH: begin
        state_d = ACCUM;
        cnt_d   = '0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Ready depends only on registered state, never on ev_valid.
  assign ev_ready    = (state_q == ACCUM);
  assign ev_accept   = ev_valid && ev_ready;
  assign ev_in_range = ({1'b0, ev_syn} < NUM_SYN_EXT);
  assign wr_in_range = ({1'b0, wr_addr} < NUM_SYN_EXT);

  // ---------------- weight register file ----------------
  // The event path reads the registered weight, so a same-cycle write to the
  // same synapse only takes effect from the next cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_SYN; i++) begin
        weight[i] <= '0;
      end
    end else if (wr_en && wr_in_range) begin
      weight[wr_addr] <= wr_data;
    end
  end

  assign w_sel = ev_in_range ? weight[ev_syn] : '0;

  // ---------------- saturating accumulate ----------------
  // One guard bit: overflow shows up as the top two bits disagreeing.
  assign sum_ext = {acc[ACC_WIDTH-1], acc}
                 + {{(ACC_WIDTH + 1 - W_WIDTH){w_sel[W_WIDTH-1]}}, w_sel};

  always_comb begin
    acc_sat = sum_ext[ACC_WIDTH-1:0];
    if (sum_ext[ACC_WIDTH] != sum_ext[ACC_WIDTH-1]) begin
      acc_sat = sum_ext[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
    end
  end

  acc_clamp #(
    .ACC_WIDTH (ACC_WIDTH)
  ) u_clamp (
    .acc     (acc),
    .current (clamp_cur)
  );

  // ---------------- accumulator and publish ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc           <= '0;
      current       <= '0;
      current_valid <= 1'b0;
      tick          <= 1'b0;
    end else begin
      current_valid <= 1'b0;
      tick          <= 1'b0;
      if (state_q == PUBLISH) begin
        current       <= clamp_cur;
        acc           <= '0;
        current_valid <= 1'b1;
        tick          <= 1'b1;
      end else if (ev_accept && ev_in_range) begin
        acc <= acc_sat;
      end
    end
  end

endmodule
